// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the stalling data-memory responder:
// FSM state encodings, operation encodings and default parameter values.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_t;

    typedef enum logic {
        DMEM_OP_RD = 1'b0,
        DMEM_OP_WR = 1'b1
    } dmem_op_t;

    localparam int DMEM_DEF_LATENCY    = 4;
    localparam int DMEM_DEF_DEPTH_LOG2 = 10;

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage for the data-memory responder: 2**DEPTH_LOG2 x 16-bit words,
// synchronous write, combinational read, whole array cleared on reset.
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DEPTH_LOG2-1:0] raddr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [15:0] mem_q [DEPTH];

    // Clear every word on reset, otherwise write one word when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle stalling data-memory responder for the MEM stage.
// Accepts one read or write per request, stalls for LATENCY-1 cycles and
// completes with a one-cycle done pulse (err alongside it for misaligned or
// conflicting requests). Optional feature macro: DMEM_DUMP_EN, which reports
// all nonzero words as "addr data" pairs on the first createdump after reset.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DMEM_DEF_DEPTH_LOG2,
    parameter int LATENCY    = DMEM_DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        createdump,
    output logic        stall,
    output logic        done,
    output logic [15:0] data_out,
    output logic        err
);

    // Counter reload: the access spends LATENCY-1 cycles in BUSY.
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_t           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    dmem_op_t              op_q, op_d;
    logic                  bad_q, bad_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [15:0]           wdata_q, wdata_d;

    logic                  stall_q, stall_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [15:0]           dout_q, dout_d;

    // Request decode from the live inputs.
    logic                  accept;
    dmem_op_t              req_op;
    logic                  req_bad;
    logic [DEPTH_LOG2-1:0] req_idx;

    // The access that completes on this edge (latched, or live when LATENCY=1).
    logic                  complete;
    dmem_op_t              cmp_op;
    logic                  cmp_bad;
    logic [DEPTH_LOG2-1:0] cmp_idx;
    logic [15:0]           cmp_wdata;

    logic                  arr_wr_en;
    logic [15:0]           arr_rdata;

    // Address bits above the word index only alias; they are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[15:DEPTH_LOG2+1];

    assign req_op  = (req_wr && !req_rd) ? DMEM_OP_WR : DMEM_OP_RD;
    assign req_bad = addr[0] | (req_rd & req_wr);
    assign req_idx = addr[DEPTH_LOG2:1];
    assign accept  = ((state_q == DMEM_IDLE) || (state_q == DMEM_DONE)) && (req_rd || req_wr);

    // Next-state, latch, completion and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        bad_d     = bad_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        complete  = 1'b0;
        cmp_op    = op_q;
        cmp_bad   = bad_q;
        cmp_idx   = idx_q;
        cmp_wdata = wdata_q;

        case (state_q)
            DMEM_IDLE, DMEM_DONE: begin
                if (accept) begin
                    op_d    = req_op;
                    bad_d   = req_bad;
                    idx_d   = req_idx;
                    wdata_d = data_in;
                    if (LATENCY == 1) begin
                        // Single-cycle access completes on the accept edge itself.
                        state_d   = DMEM_DONE;
                        complete  = 1'b1;
                        cmp_op    = req_op;
                        cmp_bad   = req_bad;
                        cmp_idx   = req_idx;
                        cmp_wdata = data_in;
                    end else begin
                        state_d = DMEM_BUSY;
                        cnt_d   = LAT_M1;
                    end
                end else begin
                    state_d = DMEM_IDLE;
                end
            end
            DMEM_BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d  = DMEM_DONE;
                    cnt_d    = 4'd0;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = DMEM_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        arr_wr_en = complete && !cmp_bad && (cmp_op == DMEM_OP_WR);

        dout_d = dout_q;
        if (complete && !cmp_bad && (cmp_op == DMEM_OP_RD)) begin
            dout_d = arr_rdata;
        end

        stall_d = (state_d == DMEM_BUSY);
        done_d  = (state_d == DMEM_DONE);
        err_d   = complete && cmp_bad;
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= DMEM_OP_RD;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            bad_q   <= bad_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            stall_q <= stall_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign stall    = stall_q;
    assign done     = done_q;
    assign err      = err_q;
    assign data_out = dout_q;

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .wr_en(arr_wr_en),
        .waddr(cmp_idx),
        .raddr(cmp_idx),
        .wdata(cmp_wdata),
        .rdata(arr_rdata)
    );

`ifdef DMEM_DUMP_EN
    logic dumped_q;

    task automatic write_dump();
        for (int i = 0; i < 2 ** DEPTH_LOG2; i++) begin
            if (u_array.mem_q[i] != 16'h0000) begin
                $display("%04h %04h", 16'(i * 2), u_array.mem_q[i]);
            end
        end
    endtask

    // Dump nonzero words once on the first createdump after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dumped_q <= 1'b0;
        end else if (createdump && !dumped_q) begin
            dumped_q <= 1'b1;
            write_dump();
        end
    end
`else
    logic unused_createdump;
    assign unused_createdump = createdump;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder. Instance 0 uses
// LATENCY=4, instance 1 uses LATENCY=1; both DEPTH_LOG2=10. A word-array
// model predicts read data, err and the stall/done timeline of each access.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic [1:0]  req_rd = 2'b00;
    logic [1:0]  req_wr = 2'b00;
    logic [15:0] addr_s [2];
    logic [15:0] din_s [2];
    logic [1:0]  createdump = 2'b00;
    logic [1:0]  stall;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [15:0] dout_s [2];

    logic [15:0] mmem [2][1024];
    logic [15:0] mdout [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst[0]), .req_rd(req_rd[0]), .req_wr(req_wr[0]),
        .addr(addr_s[0]), .data_in(din_s[0]), .createdump(createdump[0]),
        .stall(stall[0]), .done(done[0]), .data_out(dout_s[0]), .err(err[0])
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_rd(req_rd[1]), .req_wr(req_wr[1]),
        .addr(addr_s[1]), .data_in(din_s[1]), .createdump(createdump[1]),
        .stall(stall[1]), .done(done[1]), .data_out(dout_s[1]), .err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_clear(input int k);
        for (int i = 0; i < 1024; i++) mmem[k][i] = 16'h0000;
        mdout[k] = 16'h0000;
    endtask

    // One access: drive request (state must be IDLE or DONE), follow it to done.
    task automatic run_op(input int k, input bit rd, input bit wr,
                          input logic [15:0] a, input logic [15:0] d, input bit gap);
        int lat;
        bit e;
        int idx;
        lat = (k == 0) ? 4 : 1;
        e   = a[0] | (rd & wr);
        idx = int'(a[10:1]);
        req_rd[k] = rd; req_wr[k] = wr; addr_s[k] = a; din_s[k] = d;
        @(posedge clk); #1;
        if (!e) begin
            if (wr) mmem[k][idx] = d;
            if (rd) mdout[k] = mmem[k][idx];
        end
        for (int j = 0; j < lat; j++) begin
            check($sformatf("stall%0d_c%0d", k, j), 32'(stall[k]), 32'(j < lat - 1));
            check($sformatf("done%0d_c%0d", k, j), 32'(done[k]), 32'(j == lat - 1));
            if (j < lat - 1) begin
                // Requests during BUSY must be ignored.
                req_rd[k] = 1'($urandom); req_wr[k] = 1'($urandom);
                addr_s[k] = 16'($urandom); din_s[k] = 16'($urandom);
                @(posedge clk); #1;
            end
        end
        check($sformatf("err%0d", k), 32'(err[k]), 32'(e));
        check($sformatf("dout%0d", k), 32'(dout_s[k]), 32'(mdout[k]));
        $display("op k=%0d rd=%0d wr=%0d addr=%04h din=%04h -> dout=%04h err=%0d",
                 k, rd, wr, a, d, dout_s[k], err[k]);
        req_rd[k] = 1'b0; req_wr[k] = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
            check($sformatf("idle_done%0d", k), 32'(done[k]), 32'd0);
            check($sformatf("idle_stall%0d", k), 32'(stall[k]), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] a;
        int r;
        addr_s[0] = 16'h0; addr_s[1] = 16'h0; din_s[0] = 16'h0; din_s[1] = 16'h0;
        model_clear(0); model_clear(1);
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_stall%0d", k), 32'(stall[k]), 32'd0);
            check($sformatf("rst_done%0d", k), 32'(done[k]), 32'd0);
            check($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
            check($sformatf("rst_dout%0d", k), 32'(dout_s[k]), 32'd0);
        end

        // Directed sequence, LATENCY=4.
        run_op(0, 1, 0, 16'h0010, 16'h0000, 1);
        run_op(0, 0, 1, 16'h0020, 16'hBEEF, 0);
        run_op(0, 1, 0, 16'h0020, 16'h0000, 1);
        run_op(0, 1, 0, 16'h0021, 16'h0000, 1);
        run_op(0, 1, 1, 16'h0030, 16'h1234, 1);
        run_op(0, 1, 0, 16'h0030, 16'h0000, 1);
        run_op(0, 1, 0, 16'h0020, 16'h0000, 1);

        // Reset during BUSY drops the pending write and clears the array.
        req_wr[0] = 1'b1; addr_s[0] = 16'h0040; din_s[0] = 16'hA5A5;
        @(posedge clk); #1;
        req_wr[0] = 1'b0;
        check("mid_stall_before_rst", 32'(stall[0]), 32'd1);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        model_clear(0);
        check("mid_rst_stall", 32'(stall[0]), 32'd0);
        check("mid_rst_done", 32'(done[0]), 32'd0);
        check("mid_rst_dout", 32'(dout_s[0]), 32'd0);
        @(posedge clk); #1;
        check("post_rst_done", 32'(done[0]), 32'd0);
        run_op(0, 1, 0, 16'h0040, 16'h0000, 1);
        run_op(0, 1, 0, 16'h0020, 16'h0000, 1);

        // Directed sequence, LATENCY=1 with aliasing.
        run_op(1, 0, 1, 16'h0802, 16'h7777, 0);
        run_op(1, 1, 0, 16'h0002, 16'h0000, 0);
        run_op(1, 1, 0, 16'h0003, 16'h0000, 1);

        // Random traffic on both instances over a small aliased window.
        for (int n = 0; n < 300; n++) begin
            int k;
            bit rd, wr;
            k = n % 2;
            a = 16'($urandom) & 16'hF83E;
            if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
            r = $urandom_range(0, 9);
            rd = (r <= 5);
            wr = (r == 0) || (r >= 6);
            run_op(k, rd, wr, a, 16'($urandom), 1'($urandom));
            if (done[k] && (n + 1 < 300) && ((n + 1) % 2 != k)) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
